// File: rtl/keypad_event_scanner_if.sv
// Keypad scanner bundle: raw row inputs in, column drive and key event outputs back.
// The scanner takes the slave side; the keypad/controller side takes the master side.
interface keypad_event_scanner_if;
    logic [3:0] row;
    logic [3:0] shift_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport slave  (input  row, output shift_col, key_code, key_valid, key_held);
    modport master (output row, input  shift_col, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_event_scanner.sv
// 4x4 matrix keypad scanner with a single scan/debounce/held/release FSM.
// It emits one key_valid pulse per accepted press, with key_code held until the next press.
module keypad_event_scanner #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                   clk,
    input  logic                   reset,
    keypad_event_scanner_if.slave  bus
);
    localparam int DW = (SCAN_DIV > 1)        ? $clog2(SCAN_DIV)        : 1;
    localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD, ST_RELEASE} state_t;

    state_t        r_state;
    logic [3:0]    r_row_meta;
    logic [3:0]    r_row_sync;
    logic [1:0]    r_col;
    logic [1:0]    r_row_idx;
    logic [3:0]    r_pattern;
    logic [DW-1:0] r_dwell;
    logic [BW-1:0] r_db;
    logic [3:0]    r_key_code;
    logic          r_key_valid;
    logic          r_key_held;

    logic [3:0]    w_low;
    logic          w_single;
    logic          w_idle;
    logic [1:0]    w_row_enc;
    logic [3:0]    w_code;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    // A single low row is accepted; two or more lows are treated as ghosting.
    assign w_low    = ~r_row_sync;
    assign w_single = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);
    assign w_idle   = &r_row_sync;
    assign w_code   = key_map(r_row_idx, r_col);

    always_comb begin
        w_row_enc = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_low[i]) w_row_enc = 2'(i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= bus.row;
            r_row_sync <= r_row_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_SCAN;
            r_col       <= 2'd0;
            r_row_idx   <= 2'd0;
            r_pattern   <= 4'hF;
            r_dwell     <= '0;
            r_db        <= '0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            case (r_state)
                ST_SCAN: begin
                    if (r_dwell == DWELL_LAST) begin
                        r_dwell <= '0;
                        if (w_single) begin
                            r_pattern <= r_row_sync;
                            r_row_idx <= w_row_enc;
                            r_db      <= '0;
                            r_state   <= ST_DEBOUNCE;
                        end else begin
                            r_col <= r_col + 2'd1;
                        end
                    end else begin
                        r_dwell <= r_dwell + DW'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (r_row_sync == r_pattern) begin
                        if (r_db == DB_LAST) begin
                            r_key_code  <= w_code;
                            r_key_valid <= 1'b1;
                            r_key_held  <= 1'b1;
                            r_state     <= ST_HELD;
                        end else begin
                            r_db <= r_db + BW'(1);
                        end
                    end else begin
                        r_dwell <= '0;
                        r_state <= ST_SCAN;
                    end
                end
                ST_HELD: begin
                    // Rollover within the frozen column is absorbed here.
                    if (w_idle) begin
                        r_db    <= '0;
                        r_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (w_idle) begin
                        if (r_db == DB_LAST) begin
                            r_key_held <= 1'b0;
                            r_col      <= r_col + 2'd1;
                            r_dwell    <= '0;
                            r_state    <= ST_SCAN;
                        end else begin
                            r_db <= r_db + BW'(1);
                        end
                    end else begin
                        r_state <= ST_HELD;
                    end
                end
                default: r_state <= ST_SCAN;
            endcase
        end
    end

    assign bus.shift_col = ~(4'b0001 << r_col);
    assign bus.key_code  = r_key_code;
    assign bus.key_valid = r_key_valid;
    assign bus.key_held  = r_key_held;
endmodule

// File: tb/tb_keypad_event_scanner.sv
// Bench for keypad_event_scanner: a physical keypad model drives the rows from the column drive.
// Each scenario task checks event timing, codes and held/release behaviour against expected values.
module tb_keypad_event_scanner;
    localparam int SD = 4;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    keypad_event_scanner_if kif();

    keypad_event_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (kif)
    );

    logic       pressed [4][4];
    logic [3:0] row_drv;
    int         n_checks = 0;
    int         n_fail   = 0;

    // A pressed key pulls its row low only while its column is driven low.
    always_comb begin
        row_drv = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && !kif.shift_col[c]) row_drv[r] = 1'b0;
    end
    assign kif.row = row_drv;

    function automatic logic [3:0] col_mask(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c);
    endfunction

    function automatic logic [3:0] code_of(input int r, input int c);
        logic [3:0] table_v [16];
        table_v = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                    4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
        return table_v[r * 4 + c];
    endfunction

    task automatic clear_keys();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) pressed[r][c] = 1'b0;
    endtask

    // Wait for the first cycle in which column c is driven.
    task automatic align(input int c, output bit ok);
        logic [3:0] prev;
        ok = 1'b0;
        prev = kif.shift_col;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (kif.shift_col == col_mask(c) && prev != col_mask(c)) ok = 1'b1;
            prev = kif.shift_col;
        end
    endtask

    // Step n cycles recording the first pulse, pulse count, held fall and protocol violations.
    task automatic observe(input int n, output int first_v, output int n_v,
                           output int first_rel, output logic [3:0] col_rel, output int bad);
        logic prev_v, prev_h;
        prev_v = kif.key_valid;
        prev_h = kif.key_held;
        first_v = -1; n_v = 0; first_rel = -1; col_rel = 4'h0; bad = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (kif.key_valid) begin
                n_v++;
                if (first_v < 0) first_v = k;
                if (prev_v || prev_h) bad++;
            end
            if (prev_h && !kif.key_held && first_rel < 0) begin
                first_rel = k;
                col_rel = kif.shift_col;
            end
            if ($countones(~kif.shift_col) != 1) bad++;
            prev_v = kif.key_valid;
            prev_h = kif.key_held;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (kif.shift_col !== 4'b1110) begin n_fail++; $display("FAIL reset_col: got %b expected 1110", kif.shift_col); end
        n_checks++; if (kif.key_code !== 4'h0) begin n_fail++; $display("FAIL reset_code: got %h expected 0", kif.key_code); end
        n_checks++; if (kif.key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", kif.key_valid); end
        n_checks++; if (kif.key_held !== 1'b0) begin n_fail++; $display("FAIL reset_held: got %b expected 0", kif.key_held); end
    endtask

    task automatic test_idle_scan();
        int errs, pulses;
        errs = 0; pulses = 0;
        reset = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (k > 0) @(negedge clk);
            if (kif.shift_col !== col_mask((k / SD) % 4)) errs++;
            if (kif.key_valid) pulses++;
        end
        n_checks++; if (errs != 0) begin n_fail++; $display("FAIL idle_scan_order: got %0d wrong samples expected 0", errs); end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL idle_no_event: got %0d pulses expected 0", pulses); end
    endtask

    task automatic test_single_press();
        bit ok; int fv, nv, fr, bad; logic [3:0] cr;
        align(1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_align: got timeout expected col1"); end
        pressed[1][1] = 1'b1;
        observe(40, fv, nv, fr, cr, bad);
        n_checks++; if (fv != 12) begin n_fail++; $display("FAIL single_latency: got %0d expected 12", fv); end
        n_checks++; if (nv != 1) begin n_fail++; $display("FAIL single_pulses: got %0d expected 1", nv); end
        n_checks++; if (kif.key_code !== 4'h5) begin n_fail++; $display("FAIL single_code: got %h expected 5", kif.key_code); end
        n_checks++; if (kif.key_held !== 1'b1) begin n_fail++; $display("FAIL single_held: got %b expected 1", kif.key_held); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL single_protocol: got %0d violations expected 0", bad); end
        pressed[1][1] = 1'b0;
        observe(20, fv, nv, fr, cr, bad);
        n_checks++; if (fr != 11) begin n_fail++; $display("FAIL single_release: got %0d expected 11", fr); end
        n_checks++; if (cr !== 4'b1011) begin n_fail++; $display("FAIL single_resume_col: got %b expected 1011", cr); end
        n_checks++; if (nv != 0) begin n_fail++; $display("FAIL single_release_pulses: got %0d expected 0", nv); end
    endtask

    task automatic test_bounce();
        bit ok; int fv, nv, fr, bad, early; logic [3:0] cr;
        early = 0;
        align(0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bounce_align: got timeout expected col0"); end
        pressed[3][0] = 1'b1;
        repeat (3) begin @(negedge clk); if (kif.key_valid) early++; end
        pressed[3][0] = 1'b0;
        @(negedge clk); if (kif.key_valid) early++;
        pressed[3][0] = 1'b1;
        observe(30, fv, nv, fr, cr, bad);
        n_checks++; if (early != 0) begin n_fail++; $display("FAIL bounce_early: got %0d pulses expected 0", early); end
        n_checks++; if (fv != 14) begin n_fail++; $display("FAIL bounce_latency: got %0d expected 14", fv); end
        n_checks++; if (nv != 1) begin n_fail++; $display("FAIL bounce_pulses: got %0d expected 1", nv); end
        n_checks++; if (kif.key_code !== 4'hE) begin n_fail++; $display("FAIL bounce_code: got %h expected e", kif.key_code); end
    endtask

    task automatic test_rollover();
        int fv, nv, fr, bad; logic [3:0] cr;
        pressed[3][2] = 1'b1;
        observe(30, fv, nv, fr, cr, bad);
        n_checks++; if (nv != 0) begin n_fail++; $display("FAIL rollover_pulses: got %0d expected 0", nv); end
        n_checks++; if (kif.key_code !== 4'hE) begin n_fail++; $display("FAIL rollover_code: got %h expected e", kif.key_code); end
        n_checks++; if (kif.key_held !== 1'b1) begin n_fail++; $display("FAIL rollover_held: got %b expected 1", kif.key_held); end
        pressed[3][0] = 1'b0;
        pressed[3][2] = 1'b0;
        observe(20, fv, nv, fr, cr, bad);
        n_checks++; if (fr != 11) begin n_fail++; $display("FAIL rollover_release: got %0d expected 11", fr); end
        n_checks++; if (cr !== 4'b1101) begin n_fail++; $display("FAIL rollover_resume_col: got %b expected 1101", cr); end
    endtask

    task automatic test_release_glitch();
        bit ok; int fv, nv, fr, bad, drops; logic [3:0] cr;
        drops = 0;
        align(2, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL glitch_align: got timeout expected col2"); end
        pressed[2][2] = 1'b1;
        observe(30, fv, nv, fr, cr, bad);
        n_checks++; if (fv != 12 || kif.key_code !== 4'h9) begin n_fail++; $display("FAIL glitch_press: got latency %0d code %h expected 12 and 9", fv, kif.key_code); end
        pressed[2][2] = 1'b0;
        repeat (5) begin @(negedge clk); if (!kif.key_held || kif.key_valid) drops++; end
        pressed[2][2] = 1'b1;
        repeat (2) begin @(negedge clk); if (!kif.key_held || kif.key_valid) drops++; end
        pressed[2][2] = 1'b0;
        observe(20, fv, nv, fr, cr, bad);
        n_checks++; if (drops != 0) begin n_fail++; $display("FAIL glitch_held: got %0d bad cycles expected 0", drops); end
        n_checks++; if (fr != 11) begin n_fail++; $display("FAIL glitch_release: got %0d expected 11", fr); end
        n_checks++; if (nv != 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d expected 0", nv); end
        n_checks++; if (cr !== 4'b0111) begin n_fail++; $display("FAIL glitch_resume_col: got %b expected 0111", cr); end
    endtask

    task automatic test_reset_mid_debounce();
        bit ok; int fv, nv, fr, bad; logic [3:0] cr;
        align(1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_align: got timeout expected col1"); end
        pressed[0][1] = 1'b1;
        repeat (6) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (kif.shift_col !== 4'b1110) begin n_fail++; $display("FAIL rstmid_col: got %b expected 1110", kif.shift_col); end
        n_checks++; if (kif.key_code !== 4'h0) begin n_fail++; $display("FAIL rstmid_code: got %h expected 0", kif.key_code); end
        n_checks++; if (kif.key_valid !== 1'b0 || kif.key_held !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got valid %b held %b expected 0 0", kif.key_valid, kif.key_held); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        observe(30, fv, nv, fr, cr, bad);
        n_checks++; if (fv != 16) begin n_fail++; $display("FAIL rstmid_latency: got %0d expected 16", fv); end
        n_checks++; if (nv != 1 || kif.key_code !== 4'h2) begin n_fail++; $display("FAIL rstmid_event: got %0d pulses code %h expected 1 and 2", nv, kif.key_code); end
        pressed[0][1] = 1'b0;
        observe(20, fv, nv, fr, cr, bad);
        n_checks++; if (fr != 11 || cr !== 4'b1011) begin n_fail++; $display("FAIL rstmid_release: got %0d col %b expected 11 1011", fr, cr); end
    endtask

    task automatic test_random();
        int r, c, fv, nv, fr, bad; logic [3:0] cr;
        for (int it = 0; it < 10; it++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            repeat ($urandom_range(0, 15)) @(negedge clk);
            pressed[r][c] = 1'b1;
            observe(40, fv, nv, fr, cr, bad);
            n_checks++; if (nv != 1 || fv < 11 || fv > 32) begin n_fail++; $display("FAIL rand_event[%0d]: got %0d pulses at %0d expected 1 within 11..32", it, nv, fv); end
            n_checks++; if (kif.key_code !== code_of(r, c)) begin n_fail++; $display("FAIL rand_code[%0d]: got %h expected %h", it, kif.key_code, code_of(r, c)); end
            n_checks++; if (kif.key_held !== 1'b1 || bad != 0) begin n_fail++; $display("FAIL rand_held[%0d]: got held %b violations %0d expected 1 0", it, kif.key_held, bad); end
            pressed[r][c] = 1'b0;
            observe(20, fv, nv, fr, cr, bad);
            n_checks++; if (fr != 11 || cr !== col_mask((c + 1) % 4) || nv != 0) begin n_fail++; $display("FAIL rand_release[%0d]: got fall %0d col %b pulses %0d expected 11 %b 0", it, fr, cr, nv, col_mask((c + 1) % 4)); end
        end
    endtask

    initial begin
        clear_keys();
        test_reset();
        test_idle_scan();
        test_single_press();
        test_bounce();
        test_rollover();
        test_release_glitch();
        test_reset_mid_debounce();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/keypad_event_scanner.md
Name: keypad_event_scanner

Overview:
- Upstream front end of the vending machine controller: scans the 4x4 matrix keypad, synchronises and debounces it, and emits one clean event per physical key press.
- Output is a 4-bit key code plus a single-cycle valid strobe, so the controller FSM sees each press exactly once.
- Replaces separate scan and debounce stages with a single press/hold/release state machine.

Parameters:
- SCAN_DIV, 50000, clk cycles each column is driven before advancing (minimum 4).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a press or a release (minimum 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- row  in  4  keypad row inputs, active-low with external pull-ups, asynchronous to clk.
- shift_col  out  4  column drive, active-low one-hot (exactly one bit 0 at all times).
- key_code  out  4  code of the last accepted key, held until the next accepted press.
- key_valid  out  1  one-cycle pulse when a new press is accepted.
- key_held  out  1  high from the key_valid cycle until the release is accepted.

Behaviour:
- Key map (row r, column c) -> code:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
  - E is the OK key; F is the next key.
- Reset values: shift_col=4'b1110 (col0), key_code=0, key_valid=0, key_held=0, state=SCAN, all counters 0.
- row passes through a 2-FF synchroniser; rs denotes the synchronised value. All decisions use rs.
- SCAN state:
  - The column dwell counter counts 0..SCAN_DIV-1.
  - On the last dwell cycle, rs is sampled.
  - Exactly one bit low: store the row index and the current column, go to DEBOUNCE, freeze the column, clear the debounce counter.
  - rs all-high, or two or more bits low (ghosting): ignore, advance the column (col3 wraps to col0), restart the dwell counter.
- DEBOUNCE state:
  - Each cycle rs equals the stored pattern, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, in that same cycle: key_code <= mapped code, key_valid=1 for this cycle only, key_held=1, go to HELD.
  - Any cycle rs differs from the stored pattern: return to SCAN on the same column, dwell counter cleared, no event.
- HELD state:
  - The column stays frozen. Any rs value that is not all-high keeps HELD, including a second key in the same column. Rollover produces no new event.
  - rs all-high: go to RELEASE, clear the counter.
- RELEASE state:
  - Each cycle rs is all-high, the counter increments.
  - At DEBOUNCE_CYCLES-1: key_held=0, advance the column, go to SCAN.
  - Any cycle rs is not all-high: return to HELD, key_held stays 1, no new key_valid.
- Latency: row edge -> key_valid = 2 (sync) + remaining dwell + DEBOUNCE_CYCLES cycles.
- key_valid is never high on two consecutive cycles. It never asserts while key_held was already 1.
- Reset asserted mid-operation: all outputs return immediately (asynchronously) to reset values. After release, scanning restarts at col0. A key still held at that point is re-detected as a new press.
- shift_col changes only on clk edges, and only in SCAN (advance) or on exit from RELEASE.
- Counter widths are sized by $clog2 of the parameters. No counter may wrap: the debounce counter saturates at its terminal value.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
- Reset released, no keys -> shift_col cycles 1110, 1101, 1011, 0111, 1110 every 4 clks; key_valid stays 0.
- Hold row1 low while col1 is driven, for 40 clks, then release -> exactly one key_valid pulse with key_code=5; key_held=1 until 8 clks after release; scanning then resumes at col2.
- Press row3/col0 with 3-clk bounce glitches (low 3, high 1, low 3), then stable -> no event during the bounce; a single key_valid with key_code=E after 8 stable cycles.
- While E is held, press row3/col2 (F) as well -> no second key_valid; key_code stays E; release both -> key_held falls after 8 clean cycles.
- Release glitch: after a press of 9 (row2/col2), rows go high 5 clks, low 2, then high 8 -> key_held stays 1 through the glitch; no new pulse; key_held=0 after the final 8-cycle window.
- Assert reset during DEBOUNCE of key 2 -> outputs reset immediately, shift_col=1110; after reset release with key 2 still held, one key_valid with key_code=2.
